// File: rtl/mem_arbiter.sv
// Two-to-one memory bus arbiter: fetch vs load/store, one outstanding access.
// Build option ARB_RR_EN selects round-robin; otherwise load/store has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        if_size,
  output logic              if_ready,
  output logic [1:0]        if_resp,
  output logic [DATA_W-1:0] if_data_read,
  input  logic              mem_valid,
  input  logic [1:0]        mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_write,
  input  logic [1:0]        mem_size,
  output logic              mem_ready,
  output logic [1:0]        mem_resp,
  output logic [DATA_W-1:0] mem_data_read,
  output logic              out_valid,
  output logic [1:0]        out_req,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output logic [1:0]        out_size,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] out_rdata,
  input  logic [1:0]        out_resp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic       grant_mem;

`ifdef ARB_RR_EN
  // on contention the side that did not win last time goes first
  always_comb begin
    grant_mem = mem_valid && (!if_valid || !last_grant);
  end
`else
  // load/store is the older instruction, so it always wins
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  always_comb begin
    grant_mem = mem_valid;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b0;
      out_valid     <= 1'b0;
      out_req       <= 2'b00;
      out_addr      <= '0;
      out_wdata     <= '0;
      out_size      <= 2'b00;
      if_ready      <= 1'b0;
      if_resp       <= 2'b00;
      if_data_read  <= '0;
      mem_ready     <= 1'b0;
      mem_resp      <= 2'b00;
      mem_data_read <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (if_valid || mem_valid) begin
            owner      <= grant_mem;
            last_grant <= grant_mem;
            out_valid  <= 1'b1;
            out_req    <= (grant_mem && mem_req == 2'b01) ? 2'b01 : 2'b00;
            out_addr   <= grant_mem ? mem_addr : if_addr;
            out_wdata  <= grant_mem ? mem_data_write : '0;
            out_size   <= grant_mem ? mem_size : if_size;
            state      <= REQ;
          end
        end
        REQ: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= RESP;
            if (owner) begin
              mem_ready     <= 1'b1;
              mem_resp      <= out_resp;
              mem_data_read <= out_rdata;
            end else begin
              if_ready      <= 1'b1;
              if_resp       <= out_resp;
              if_data_read  <= out_rdata;
            end
          end
        end
        // ready pulse cycle: no grant, so a still-high valid is not re-granted
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus random traffic.
// Expected outputs come from a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic        if_ready;
  logic [1:0]  if_resp;
  logic [63:0] if_data_read;
  logic        mem_valid;
  logic [1:0]  mem_req;
  logic [63:0] mem_addr;
  logic [63:0] mem_data_write;
  logic [1:0]  mem_size;
  logic        mem_ready;
  logic [1:0]  mem_resp;
  logic [63:0] mem_data_read;
  logic        out_valid;
  logic [1:0]  out_req;
  logic [63:0] out_addr;
  logic [63:0] out_wdata;
  logic [1:0]  out_size;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic [1:0]  out_resp;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
    .if_ready(if_ready), .if_resp(if_resp), .if_data_read(if_data_read),
    .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_write(mem_data_write), .mem_size(mem_size),
    .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_data_read(mem_data_read),
    .out_valid(out_valid), .out_req(out_req), .out_addr(out_addr),
    .out_wdata(out_wdata), .out_size(out_size),
    .out_ready(out_ready), .out_rdata(out_rdata), .out_resp(out_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // transaction-level model: one access in flight, then a completion cycle
  logic        m_busy, m_owner_mem, m_last_mem, m_if_rdy, m_mem_rdy;
  logic [1:0]  m_req, m_size, m_if_r, m_mem_r;
  logic [63:0] m_addr, m_wdata, m_if_d, m_mem_d;
  logic        seen_if_rdy, seen_mem_rdy;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner_mem = 0; m_last_mem = 0;
    m_if_rdy = 0; m_mem_rdy = 0;
    m_req = 0; m_size = 0; m_addr = 0; m_wdata = 0;
    m_if_r = 0; m_if_d = 0; m_mem_r = 0; m_mem_d = 0;
  endtask

  task automatic model_step();
    logic completing;
    logic pick_mem;
    if (!rst) begin
      model_reset();
      return;
    end
    completing = m_if_rdy | m_mem_rdy;
    m_if_rdy = 0;
    m_mem_rdy = 0;
    if (m_busy) begin
      if (out_ready) begin
        m_busy = 0;
        if (m_owner_mem) begin
          m_mem_rdy = 1; m_mem_d = out_rdata; m_mem_r = out_resp;
        end else begin
          m_if_rdy = 1; m_if_d = out_rdata; m_if_r = out_resp;
        end
      end
    end else if (!completing && (if_valid || mem_valid)) begin
`ifdef ARB_RR_EN
      if (if_valid && mem_valid) pick_mem = !m_last_mem;
      else pick_mem = mem_valid;
`else
      pick_mem = mem_valid;
`endif
      m_busy = 1;
      m_owner_mem = pick_mem;
      m_last_mem = pick_mem;
      if (pick_mem) begin
        m_req = (mem_req == 2'b01) ? 2'b01 : 2'b00;
        m_addr = mem_addr; m_wdata = mem_data_write; m_size = mem_size;
      end else begin
        m_req = 2'b00; m_addr = if_addr; m_wdata = 0; m_size = if_size;
      end
    end
  endtask

  // mid-cycle compare of every output against the model
  task automatic half();
    @(negedge clk);
    seen_if_rdy = if_ready;
    seen_mem_rdy = mem_ready;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_busy});
    chk("out_req", {62'd0, out_req}, {62'd0, m_req});
    chk("out_addr", out_addr, m_addr);
    chk("out_wdata", out_wdata, m_wdata);
    chk("out_size", {62'd0, out_size}, {62'd0, m_size});
    chk("if_ready", {63'd0, if_ready}, {63'd0, m_if_rdy});
    chk("mem_ready", {63'd0, mem_ready}, {63'd0, m_mem_rdy});
    chk("if_resp", {62'd0, if_resp}, {62'd0, m_if_r});
    chk("if_data_read", if_data_read, m_if_d);
    chk("mem_resp", {62'd0, mem_resp}, {62'd0, m_mem_r});
    chk("mem_data_read", mem_data_read, m_mem_d);
    chk("ready_excl", {63'd0, if_ready & mem_ready}, 64'd0);
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic new_if();
    if_valid = 1;
    if_addr = {$urandom, $urandom};
    if_size = 2'($urandom_range(0, 3));
  endtask

  task automatic new_mem();
    mem_valid = 1;
    mem_req = 2'($urandom_range(0, 3));
    mem_addr = {$urandom, $urandom};
    mem_data_write = {$urandom, $urandom};
    mem_size = 2'($urandom_range(0, 3));
  endtask

  initial begin
    logic [63:0] exp_addr;
    model_reset();
    rst = 0;
    if_valid = 0; if_addr = 0; if_size = 0;
    mem_valid = 0; mem_req = 0; mem_addr = 0; mem_data_write = 0; mem_size = 0;
    out_ready = 0; out_rdata = 0; out_resp = 0;
    adv();
    adv();
    rst = 1;
    half();
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_if_data", if_data_read, 64'd0);
    adv();

    // single fetch, downstream answers at once
    if_valid = 1; if_addr = 64'h8000_0000; if_size = 2'b10;
    half(); adv();
    out_ready = 1; out_rdata = 64'h0000_0013_0000_0093; out_resp = 2'b00;
    half();
    chk("fetch_out_valid", {63'd0, out_valid}, 64'd1);
    chk("fetch_out_addr", out_addr, 64'h8000_0000);
    chk("fetch_out_req", {62'd0, out_req}, 64'd0);
    chk("fetch_out_wdata", out_wdata, 64'd0);
    adv();
    out_ready = 0; if_valid = 0;
    half();
    chk("fetch_if_ready", {63'd0, if_ready}, 64'd1);
    chk("fetch_if_data", if_data_read, 64'h0000_0013_0000_0093);
    adv();
    half();
    chk("fetch_idle", {63'd0, out_valid | if_ready}, 64'd0);
    adv();

    // store with four wait states
    mem_valid = 1; mem_req = 2'b01; mem_addr = 64'h8000_1000;
    mem_data_write = 64'hDEAD_BEEF; mem_size = 2'b11;
    half(); adv();
    for (int i = 1; i <= 5; i++) begin
      out_ready = (i == 5); out_rdata = 64'h1234; out_resp = 2'b00;
      half();
      chk("store_out_valid", {63'd0, out_valid}, 64'd1);
      chk("store_out_addr", out_addr, 64'h8000_1000);
      chk("store_out_wdata", out_wdata, 64'hDEAD_BEEF);
      chk("store_out_req", {62'd0, out_req}, 64'd1);
      adv();
    end
    out_ready = 0; mem_valid = 0;
    half();
    chk("store_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("store_mem_resp", {62'd0, mem_resp}, 64'd0);
    adv();
    half(); adv();

    // contention from a fresh reset
    rst = 0;
    half(); adv();
    rst = 1;
    if_valid = 1; if_addr = 64'h1000; if_size = 2'b10;
    mem_valid = 1; mem_req = 2'b00; mem_addr = 64'h2000; mem_size = 2'b11;
    for (int t = 0; t < 4; t++) begin
      half(); adv();
      out_ready = 1; out_rdata = 64'(t); out_resp = 2'b00;
      half();
`ifdef ARB_RR_EN
      exp_addr = (t % 2 == 0) ? 64'h2000 : 64'h1000;
`else
      exp_addr = 64'h2000;
`endif
      chk("contend_grant", out_addr, exp_addr);
      adv();
      out_ready = 0;
      half(); adv();
    end
    mem_valid = 0;
    half(); adv();
    out_ready = 1;
    half();
    chk("contend_fetch_after", out_addr, 64'h1000);
    adv();
    out_ready = 0; if_valid = 0;
    half(); adv();
    half(); adv();

    // fetch valid held through its ready, address changed afterwards
    if_valid = 1; if_addr = 64'h3000;
    half(); adv();
    out_ready = 1;
    half();
    chk("stale_first", out_addr, 64'h3000);
    adv();
    out_ready = 0;
    half();
    chk("stale_ready", {63'd0, if_ready}, 64'd1);
    adv();
    if_addr = 64'h3008;
    half();
    chk("stale_no_regrant", {63'd0, out_valid}, 64'd0);
    adv();
    out_ready = 1;
    half();
    chk("stale_second", out_addr, 64'h3008);
    adv();
    out_ready = 0; if_valid = 0;
    half(); adv();
    half();
    chk("stale_no_dup", {63'd0, out_valid}, 64'd0);
    adv();

    // reset while a request is outstanding
    mem_valid = 1; mem_req = 2'b01; mem_addr = 64'h4000; mem_data_write = 64'h55;
    half(); adv();
    half();
    chk("rst_req_valid", {63'd0, out_valid}, 64'd1);
    adv();
    rst = 0;
    half(); adv();
    rst = 1; mem_valid = 0;
    half();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_addr", out_addr, 64'd0);
    chk("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    chk("rst_mem_data", mem_data_read, 64'd0);
    adv();
    mem_valid = 1; mem_req = 2'b00; mem_addr = 64'h5000;
    half(); adv();
    out_ready = 1; out_rdata = 64'hCAFE_F00D; out_resp = 2'b10;
    half(); adv();
    out_ready = 0; mem_valid = 0;
    half();
    chk("rst_fresh_ready", {63'd0, mem_ready}, 64'd1);
    chk("rst_fresh_data", mem_data_read, 64'hCAFE_F00D);
    chk("rst_fresh_resp", {62'd0, mem_resp}, 64'd2);
    adv();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      half(); adv();
      rst = ($urandom_range(0, 399) != 0);
      if (if_valid) begin
        if (seen_if_rdy) begin
          if ($urandom_range(0, 1) == 1) new_if();
          else if_valid = 0;
        end
      end else if ($urandom_range(0, 2) == 0) new_if();
      if (mem_valid) begin
        if (seen_mem_rdy) begin
          if ($urandom_range(0, 1) == 1) new_mem();
          else mem_valid = 0;
        end
      end else if ($urandom_range(0, 2) == 0) new_mem();
      out_ready = ($urandom_range(0, 2) == 0);
      out_rdata = {$urandom, $urandom};
      out_resp = 2'($urandom_range(0, 3));
    end
    half();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
